// File: rtl/majority_uart_rx.sv
// Oversampled UART receiver: 2-of-3 vote around each bit centre; MAJORITY_RX_PARITY_EN adds an even-parity bit.
// Latency: pulse 2 + (1+DATA_BITS[+1])*CLKS_PER_BIT + M+2 clocks after the start edge on rx.
// Backpressure: none; data_valid/frame_err/parity_err are single-cycle pulses, data_out holds.
module majority_uart_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 frame_err,
   output logic                 noise_det,
`ifdef MAJORITY_RX_PARITY_EN
   output logic                 parity_err,
`endif
   output logic                 busy
);

   localparam int M  = CLKS_PER_BIT / 2;
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_BITS);

   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_S0   = CW'(M - 1);
   localparam logic [CW-1:0] CNT_S1   = CW'(M);
   localparam logic [CW-1:0] CNT_S2   = CW'(M + 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
`ifdef MAJORITY_RX_PARITY_EN
      PARITY  = 3'd3,
`endif
      STOP    = 3'd4,
      WAIT_HI = 3'd5
   } state_t;

   state_t               state, state_nxt;
   logic                 rx_meta, rx_s;
   logic [CW-1:0]        cnt;
   logic [IW-1:0]        bit_idx;
   logic                 s0, s1;
   logic                 vote, disagree;
   logic                 in_frame, vote_evt, cnt_wrap, last_bit;
   logic [DATA_BITS-1:0] shift;
   logic                 noise_flag;
   logic                 word_ok, word_bad;
`ifdef MAJORITY_RX_PARITY_EN
   logic                 par_bit, par_good, par_bad;
`endif

   // Two-flop synchroniser; idles high so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   always_comb begin
      in_frame = (state == START) || (state == DATA) || (state == STOP);
`ifdef MAJORITY_RX_PARITY_EN
      if (state == PARITY)
         in_frame = 1'b1;
`endif
   end

   // The third sample is the live rx_s, so the vote resolves in the cnt=M+1 cycle.
   assign vote     = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
   assign disagree = (s0 != s1) || (s1 != rx_s);
   assign vote_evt = in_frame && (cnt == CNT_S2);
   assign cnt_wrap = in_frame && (cnt == CNT_LAST);
   assign last_bit = (bit_idx == IDX_LAST);
`ifdef MAJORITY_RX_PARITY_EN
   assign par_good = ~^{shift, par_bit};
`endif

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!rx_s) state_nxt = START;
         START: begin
            if (vote_evt && vote)
               state_nxt = IDLE;
            else if (cnt_wrap)
               state_nxt = DATA;
         end
         DATA: begin
            if (cnt_wrap && last_bit)
`ifdef MAJORITY_RX_PARITY_EN
               state_nxt = PARITY;
`else
               state_nxt = STOP;
`endif
         end
`ifdef MAJORITY_RX_PARITY_EN
         PARITY:  if (cnt_wrap) state_nxt = STOP;
`endif
         // Decided at the stop-bit vote so a following start bit is never missed.
         STOP:    if (vote_evt) state_nxt = vote ? IDLE : WAIT_HI;
         WAIT_HI: if (rx_s) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state != IDLE);
      word_ok  = 1'b0;
      word_bad = 1'b0;
`ifdef MAJORITY_RX_PARITY_EN
      par_bad  = 1'b0;
`endif
      if ((state == STOP) && vote_evt) begin
         if (!vote)
            word_bad = 1'b1;
`ifdef MAJORITY_RX_PARITY_EN
         else if (!par_good)
            par_bad = 1'b1;
`endif
         else
            word_ok = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         bit_idx    <= '0;
         s0         <= 1'b1;
         s1         <= 1'b1;
         shift      <= '0;
         noise_flag <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         noise_det  <= 1'b0;
`ifdef MAJORITY_RX_PARITY_EN
         par_bit    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         noise_det  <= 1'b0;
`ifdef MAJORITY_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         // The detect cycle is cnt 0, so START begins at cnt 1.
         if (state == IDLE) begin
            cnt <= rx_s ? '0 : CW'(1);
            if (!rx_s) begin
               noise_flag <= 1'b0;
               bit_idx    <= '0;
            end
         end else if (in_frame) begin
            cnt <= cnt_wrap ? '0 : cnt + 1'b1;
         end else begin
            cnt <= '0;
         end

         if (in_frame && (cnt == CNT_S0))
            s0 <= rx_s;
         if (in_frame && (cnt == CNT_S1))
            s1 <= rx_s;
         if (vote_evt)
            noise_flag <= noise_flag | disagree;

         if (vote_evt && (state == DATA))
            shift <= {vote, shift[DATA_BITS-1:1]};
         if (cnt_wrap && (state == DATA) && !last_bit)
            bit_idx <= bit_idx + 1'b1;
`ifdef MAJORITY_RX_PARITY_EN
         if (vote_evt && (state == PARITY))
            par_bit <= vote;
         if (par_bad) begin
            parity_err <= 1'b1;
            noise_det  <= noise_flag | disagree;
         end
`endif

         if (word_ok) begin
            data_out   <= shift;
            data_valid <= 1'b1;
            noise_det  <= noise_flag | disagree;
         end
         if (word_bad) begin
            frame_err  <= 1'b1;
            noise_det  <= noise_flag | disagree;
         end
      end
   end

endmodule

// File: tb/tb_majority_uart_rx.sv
// Scoreboard bench for majority_uart_rx: directed frames push expectations, a negedge monitor pops and compares.
// Build with MAJORITY_RX_PARITY_EN to exercise the parity variant.
module tb_majority_uart_rx;

   localparam int C  = 16;
   localparam int DB = 8;
   localparam int M  = C / 2;
   localparam int K_DATA = 0;
   localparam int K_FERR = 1;
   localparam int K_PERR = 2;

   typedef struct {
      int         kind;
      logic [7:0] data;
      logic       noise;
      int         exp_cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          rx;
   logic [DB-1:0] data_out;
   logic          data_valid, frame_err, noise_det, busy;
   logic          perr_w;
`ifdef MAJORITY_RX_PARITY_EN
   logic          parity_err;
   assign perr_w = parity_err;
`else
   assign perr_w = 1'b0;
`endif

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   exp_t sbq[$];
   logic [7:0] last_good = '0;

   majority_uart_rx #(.CLKS_PER_BIT(C), .DATA_BITS(DB)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .data_out   (data_out),
      .data_valid (data_valid),
      .frame_err  (frame_err),
      .noise_det  (noise_det),
`ifdef MAJORITY_RX_PARITY_EN
      .parity_err (parity_err),
`endif
      .busy       (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // glitch_bit/abort_bit are frame bit indices (0 = start); -1 disables.
   task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip,
                             input int glitch_bit, input int abort_bit);
      logic [10:0] bits;
      int          nb;
      exp_t        e;
      bits    = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = d[i];
`ifdef MAJORITY_RX_PARITY_EN
      bits[9]  = (^d) ^ par_flip;
      bits[10] = stop;
      nb       = 11;
`else
      bits[9]  = stop;
      nb       = 10;
`endif
      if (abort_bit < 0) begin
         e.kind    = !stop ? K_FERR : (par_flip ? K_PERR : K_DATA);
         e.data    = d;
         e.noise   = (glitch_bit >= 0);
         e.exp_cyc = cyc + 2 + (nb - 1) * C + M + 2;
         sbq.push_back(e);
      end
      for (int b = 0; b < nb; b++) begin
         for (int o = 0; o < C; o++) begin
            if ((b == abort_bit) && (o == M)) begin
               rst = 1'b1;
               tick();
               rst = 1'b0;
               rx  = 1'b1;
               check("abort_busy", busy, 0);
               check("abort_dout", data_out, 0);
               check("abort_dv", data_valid, 0);
               check("abort_ferr", frame_err, 0);
               check("abort_noise", noise_det, 0);
               return;
            end
            rx = bits[b] ^ ((b == glitch_bit) && (o == M));
            tick();
         end
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      int   kind, lat;
      if (rst) begin
         last_good = '0;
      end else if (data_valid || frame_err || perr_w) begin
         check("one_pulse", $countones({data_valid, frame_err, perr_w}), 1);
         if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse: dv=%0b ferr=%0b perr=%0b at cycle %0d, none expected",
                     data_valid, frame_err, perr_w, cyc);
         end else begin
            e    = sbq.pop_front();
            kind = data_valid ? K_DATA : (frame_err ? K_FERR : K_PERR);
            check("pulse_kind", kind, e.kind);
            check("noise_det", noise_det, e.noise);
            if (e.kind == K_DATA) begin
               check("data_out", data_out, e.data);
               last_good = e.data;
            end else begin
               check("dout_held", data_out, last_good);
            end
            lat = cyc - e.exp_cyc;
            checks++;
            if (lat < -1 || lat > 1) begin
               failures++;
               $display("FAIL latency: pulse at cycle %0d, expected cycle %0d +/-1", cyc, e.exp_cyc);
            end
         end
      end else begin
         check("noise_idle", noise_det, 0);
         check("dout_hold", data_out, last_good);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      check("rst_dout", data_out, 0);
      check("rst_dv", data_valid, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_noise", noise_det, 0);
      check("rst_busy", busy, 0);
      repeat (10) tick();

      send_frame(8'hA5, 1'b1, 1'b0, -1, -1);
      send_frame(8'hA5, 1'b1, 1'b0, 4, -1);

      // Three-clock low blip: qualified as a false start at the vote.
      rx = 1'b0;
      repeat (3) tick();
      rx = 1'b1;
      repeat (3) tick();
      check("false_start_busy", busy, 1);
      repeat (14) tick();
      check("false_start_idle", busy, 0);

      // Bad stop bit, break held low, then recovery.
      send_frame(8'h3C, 1'b0, 1'b0, -1, -1);
      rx = 1'b0;
      repeat (24) tick();
      check("break_busy", busy, 1);
      rx = 1'b1;
      repeat (20) tick();
      check("break_released", busy, 0);
      send_frame(8'h12, 1'b1, 1'b0, -1, -1);

      // Reset during data bit 4 of 0xFF.
      send_frame(8'hFF, 1'b1, 1'b0, -1, 5);
      repeat (20) tick();
      send_frame(8'h55, 1'b1, 1'b0, -1, -1);
      send_frame(8'h80, 1'b1, 1'b0, -1, -1);

`ifdef MAJORITY_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b1, -1, -1);
      send_frame(8'h07, 1'b1, 1'b0, -1, -1);
`endif
      rx = 1'b1;
      for (int i = 0; i < 400 && sbq.size() > 0; i++) tick();
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         checks++;
         failures++;
         $display("FAIL missing_pulse: kind %0d data %0h never seen, expected by cycle %0d",
                  e.kind, e.data, e.exp_cyc);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
